instr_fetch_unit: RTL and testbench

//  Upstream stage of simple_cpu: holds the program, keeps the PC and presents one instruction at a time.
//  The CPU takes several cycles per instruction, so the handshake is valid/ack.

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundles the program-load, run control and instruction-issue signals
// between the instruction fetch unit and its environment.
interface instr_fetch_if #(
   parameter int INSTR_WIDTH = 20,
   parameter int PC_BITS     = 5,
   parameter int COUNT_WIDTH = 8
);
   logic                   prog_we;
   logic [PC_BITS-1:0]     prog_addr;
   logic [INSTR_WIDTH-1:0] prog_data;
   logic                   run;
   logic                   instr_ack;
   logic [INSTR_WIDTH-1:0] instr_out;
   logic                   instr_valid;
   logic [PC_BITS-1:0]     pc_out;
   logic                   halted;
   logic [COUNT_WIDTH-1:0] issued_cnt;

   modport master (
      output prog_we, prog_addr, prog_data, run, instr_ack,
      input  instr_out, instr_valid, pc_out, halted, issued_cnt
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, run, instr_ack,
      output instr_out, instr_valid, pc_out, halted, issued_cnt
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Holds the program, keeps the PC and hands one instruction at a time to the CPU.
// Control words (opcode 00) are consumed here: all-zero is HALT, anything else is JUMP.
module instr_fetch_unit #(
   parameter int INSTR_WIDTH = 20,
   parameter int PC_BITS     = 5,
   parameter int COUNT_WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   instr_fetch_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_PRESENT = 3'd3,
      S_HALT    = 3'd4
   } state_e;

   localparam int DEPTH = 2 ** PC_BITS;

   state_e                 state_q, state_d;
   logic [PC_BITS-1:0]     pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   valid_q, valid_d;
   logic                   halted_q, halted_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [INSTR_WIDTH-1:0] mem [DEPTH];
   logic [INSTR_WIDTH-1:0] rdata_q;
   logic                   mem_we;
   logic                   word_is_halt;
   logic                   word_is_jump;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign mem_we       = bus.prog_we && (state_q == S_IDLE || state_q == S_HALT);
   assign word_is_halt = (rdata_q == '0);
   assign word_is_jump = (rdata_q[INSTR_WIDTH-1 -: 2] == 2'b00) && !word_is_halt;

   // Program memory: loads only while stopped, read is registered on leaving FETCH
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[bus.prog_addr] <= bus.prog_data;
      end
      if (state_q == S_FETCH) begin
         rdata_q <= mem[pc_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.run && !bus.prog_we) state_d = S_FETCH;
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            if (word_is_halt)      state_d = S_HALT;
            else if (word_is_jump) state_d = S_FETCH;
            else                   state_d = S_PRESENT;
         end
         S_PRESENT: if (bus.instr_ack) state_d = bus.run ? S_FETCH : S_IDLE;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_DECODE: begin
            if (word_is_halt) begin
               halted_d = 1'b1;
            end else if (word_is_jump) begin
               pc_d = rdata_q[PC_BITS-1:0];
            end else begin
               instr_d = rdata_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 1'b1;
               cnt_d   = sat_inc(cnt_q);
            end
         end
         S_PRESENT: if (bus.instr_ack) valid_d = 1'b0;
         default: ;
      endcase
   end

   assign bus.instr_out   = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc_out      = pc_q;
   assign bus.halted      = halted_q;
   assign bus.issued_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: issue order, latency, jumps, back-pressure,
// PC wrap, write gating and reset behaviour.
module tb_instr_fetch_unit;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   instr_fetch_if #(.INSTR_WIDTH(20), .PC_BITS(5), .COUNT_WIDTH(8)) bus ();

   instr_fetch_unit #(.INSTR_WIDTH(20), .PC_BITS(5), .COUNT_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.run = 1'b0;
      bus.instr_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load(input logic [4:0] addr, input logic [19:0] data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = addr;
      bus.prog_data = data;
      tick();
      bus.prog_we   = 1'b0;
   endtask

   // Trigger (run raise or ack) is already applied; n edges later the word must be valid.
   task automatic expect_issue(input string tag, input int n, input logic [19:0] word,
                               input logic [4:0] pc, input logic [7:0] cnt);
      for (int i = 0; i < n; i++) begin
         tick();
         if (i == 0) bus.instr_ack = 1'b0;
         if (i < n - 1) chk({tag, "_gap_valid"}, bus.instr_valid, 1'b0);
      end
      chk({tag, "_valid"}, bus.instr_valid, 1'b1);
      chk({tag, "_instr"}, bus.instr_out, word);
      chk({tag, "_pc"}, bus.pc_out, pc);
      chk({tag, "_cnt"}, bus.issued_cnt, cnt);
   endtask

   task automatic expect_halt(input string tag, input int n, input logic [4:0] pc,
                              input logic [7:0] cnt);
      for (int i = 0; i < n; i++) begin
         tick();
         if (i == 0) bus.instr_ack = 1'b0;
         if (i == n - 2) chk({tag, "_not_yet_halted"}, bus.halted, 1'b0);
      end
      chk({tag, "_halted"}, bus.halted, 1'b1);
      chk({tag, "_valid"}, bus.instr_valid, 1'b0);
      chk({tag, "_pc"}, bus.pc_out, pc);
      chk({tag, "_cnt"}, bus.issued_cnt, cnt);
   endtask

   initial begin
      bus.prog_we   = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.run       = 1'b0;
      bus.instr_ack = 1'b0;

      // Reset held for two edges with run high: nothing may start
      rst = 1'b1;
      bus.run = 1'b1;
      tick();
      tick();
      chk("rst_valid", bus.instr_valid, 1'b0);
      chk("rst_pc", bus.pc_out, 5'd0);
      chk("rst_halted", bus.halted, 1'b0);
      chk("rst_cnt", bus.issued_cnt, 8'd0);
      chk("rst_instr", bus.instr_out, 20'h0);
      bus.run = 1'b0;
      rst = 1'b0;
      bus.instr_ack = 1'b1;
      tick();
      tick();
      bus.instr_ack = 1'b0;
      chk("idle_ack_valid", bus.instr_valid, 1'b0);
      chk("idle_ack_pc", bus.pc_out, 5'd0);

      // Straight-line issue sequence ending in HALT
      load(5'd0, 20'h47000);
      load(5'd1, 20'h53000);
      load(5'd2, 20'h72001);
      load(5'd3, 20'hD80F0);
      load(5'd4, 20'h00000);
      bus.run = 1'b1;
      expect_issue("seq0", 3, 20'h47000, 5'd1, 8'd1);
      bus.instr_ack = 1'b1;
      expect_issue("seq1", 3, 20'h53000, 5'd2, 8'd2);
      bus.instr_ack = 1'b1;
      expect_issue("seq2", 3, 20'h72001, 5'd3, 8'd3);
      bus.instr_ack = 1'b1;
      expect_issue("seq3", 3, 20'hD80F0, 5'd4, 8'd4);
      bus.instr_ack = 1'b1;
      expect_halt("seq_halt", 3, 5'd4, 8'd4);
      bus.run = 1'b0;
      tick();
      tick();
      chk("halt_sticky", bus.halted, 1'b1);

      // JUMP is consumed, never issued
      do_reset();
      load(5'd0, 20'h47000);
      load(5'd1, 20'h00005);
      load(5'd5, 20'h53000);
      load(5'd6, 20'h00000);
      bus.run = 1'b1;
      expect_issue("jmp0", 3, 20'h47000, 5'd1, 8'd1);
      bus.instr_ack = 1'b1;
      expect_issue("jmp1", 5, 20'h53000, 5'd6, 8'd2);
      bus.instr_ack = 1'b1;
      expect_halt("jmp_halt", 3, 5'd6, 8'd2);

      // Back-pressure, pause to IDLE and resume; run dropped during FETCH
      do_reset();
      load(5'd0, 20'h47000);
      load(5'd1, 20'h53000);
      load(5'd2, 20'h00000);
      bus.run = 1'b1;
      expect_issue("bp0", 3, 20'h47000, 5'd1, 8'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_valid", bus.instr_valid, 1'b1);
         chk("bp_hold_instr", bus.instr_out, 20'h47000);
         chk("bp_hold_pc", bus.pc_out, 5'd1);
      end
      bus.run = 1'b0;
      bus.instr_ack = 1'b1;
      tick();
      bus.instr_ack = 1'b0;
      chk("pause_valid", bus.instr_valid, 1'b0);
      tick();
      tick();
      tick();
      chk("pause_idle_valid", bus.instr_valid, 1'b0);
      chk("pause_pc", bus.pc_out, 5'd1);
      bus.run = 1'b1;
      tick();
      bus.run = 1'b0;
      chk("drop_fetch_valid", bus.instr_valid, 1'b0);
      tick();
      chk("drop_decode_valid", bus.instr_valid, 1'b0);
      tick();
      chk("drop_present_valid", bus.instr_valid, 1'b1);
      chk("drop_present_instr", bus.instr_out, 20'h53000);
      chk("drop_present_pc", bus.pc_out, 5'd2);
      bus.instr_ack = 1'b1;
      tick();
      bus.instr_ack = 1'b0;
      tick();
      tick();
      chk("drop_idle_valid", bus.instr_valid, 1'b0);
      chk("drop_idle_halted", bus.halted, 1'b0);
      bus.run = 1'b1;
      expect_halt("bp_halt", 3, 5'd2, 8'd2);

      // PC wrap from 31 to 0; writes ignored while presenting
      do_reset();
      load(5'd0, 20'h0001F);
      load(5'd31, 20'h47000);
      bus.run = 1'b1;
      expect_issue("wrap0", 5, 20'h47000, 5'd0, 8'd1);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 5'd0;
      bus.prog_data = 20'h53000;
      tick();
      bus.prog_we   = 1'b0;
      chk("we_present_valid", bus.instr_valid, 1'b1);
      bus.instr_ack = 1'b1;
      expect_issue("wrap1", 5, 20'h47000, 5'd0, 8'd2);
      bus.run = 1'b0;
      bus.instr_ack = 1'b1;
      tick();
      bus.instr_ack = 1'b0;
      tick();
      chk("wrap_idle_valid", bus.instr_valid, 1'b0);
      load(5'd0, 20'h00000);
      bus.run = 1'b1;
      expect_halt("wrap_halt", 3, 5'd0, 8'd2);

      // Reset while an instruction is waiting for ack
      do_reset();
      load(5'd0, 20'h47000);
      load(5'd1, 20'h00000);
      bus.run = 1'b1;
      expect_issue("mid0", 3, 20'h47000, 5'd1, 8'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.run = 1'b0;
      chk("mid_rst_valid", bus.instr_valid, 1'b0);
      chk("mid_rst_pc", bus.pc_out, 5'd0);
      chk("mid_rst_halted", bus.halted, 1'b0);
      chk("mid_rst_cnt", bus.issued_cnt, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
